machine_timer_unit: RTL
=======================

// Module: machine_timer_unit
// PURPOSE
//  Memory-mapped machine timer: free-running 64-bit mtime, 64-bit mtimecmp, and a prescaler.
//  Drives the level-sensitive timer_interrupt_request consumed by the core's CSR file (mip.MTIP).
//  Sits on the data-bus peripheral segment as a word-only slave with 1-cycle read latency.
// PARAMETERS
//  PRESCALE_WIDTH  8                       width of the prescaler divider field and counter
//  MTIMECMP_RESET  64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp (no interrupt out of reset)
// PORTS
//  clk                      in   1   core clock
//  rst_n                    in   1   asynchronous active-low reset
//  bus_address              in   5   byte offset in block; bits[1:0] ignored
//  bus_read_enable          in   1   read request, 1-cycle pulse
//  bus_write_enable         in   1   write request, 1-cycle pulse, full word
//  bus_write_data           in   32  write data
//  bus_read_data            out  32  read data, valid when bus_read_valid=1
//  bus_read_valid           out  1   high exactly one cycle after an accepted read
//  timer_interrupt_request  out  1   registered (mtime >= mtimecmp), level
// BEHAVIOUR
//  Register map (offset): 0x00 MTIME_LO, 0x04 MTIME_HI (shadow on read), 0x08 MTIMECMP_LO,
//   0x0C MTIMECMP_HI, 0x10 CTRL {bit0 ENABLE, bits[8+PW-1:8] DIVIDER}; others read 0, writes ignored.
//  Reset: mtime=0, hi_shadow=0, mtimecmp=MTIMECMP_RESET, ENABLE=1, DIVIDER=0, prescale count=0,
//   bus_read_data=0, bus_read_valid=0, timer_interrupt_request=0.
//  Prescaler: count runs 0..DIVIDER; tick when ENABLE && count==DIVIDER, then count<=0; DIVIDER=0
//   -> tick every cycle. ENABLE=0 holds count and mtime. A write to CTRL resets count to 0.
//  mtime: +1 on tick, unsigned 64-bit, FFFF_FFFF_FFFF_FFFF wraps to 0 (carry lo->hi same cycle).
//  Write to MTIME_LO/HI replaces that half; the tick in that same cycle is dropped for the whole
//   64-bit value (no increment, no carry into the other half).
//  Reads: data registered; bus_read_valid asserted the next cycle. Reading MTIME_LO returns mtime[31:0]
//   and copies mtime[63:32] into hi_shadow in that same cycle; reading MTIME_HI returns hi_shadow,
//   giving a tear-free LO-then-HI 64-bit read. Reading MTIME_HI alone returns the last shadow.
//  Read and write in the same cycle: the write is performed; the read returns the pre-write value.
//  Interrupt: cmp = (mtime >= mtimecmp), unsigned 64-bit, registered -> 1-cycle latency from any
//   mtime/mtimecmp change. Stays high until software moves mtimecmp above mtime (no auto-clear).
//   Software rewrites mtimecmp as HI=FFFF_FFFF, LO, HI to avoid spurious matches; the hardware
//   adds no special handling.
//  Async reset mid-access: the pending bus_read_valid is dropped; all state returns to reset values.
// STRUCTURE
//  Shared package timer_pkg: register offset localparams (MTIME_LO..CTRL), CTRL bit positions.
//  One sub-module, timer_prescaler (PRESCALE_WIDTH): enable, divider, clear in; tick out.
//  Top: register file, 64-bit counter, shadow, comparator register, read mux/register.
// TESTING
//  1 Reset: read all offsets -> MTIME=0, MTIMECMP=FFFF_FFFF/FFFF_FFFF, CTRL=0x1, irq=0.
//  2 DIVIDER=3 via CTRL, run 40 cycles -> mtime advances exactly 10; ENABLE=0 -> mtime frozen.
//  3 Write MTIME_LO=FFFF_FFFF, HI=FFFF_FFFF, DIVIDER=0, 1 tick -> mtime=0 (hi and lo both 0).
//  4 mtime=0x0000_0001_FFFF_FFFE; read LO at the cycle before the carry, then HI -> HI=0x1, not 0x2.
//  5 mtimecmp=0x20, mtime from 0 with DIVIDER=0 -> irq rises 1 cycle after mtime==0x20; write
//    MTIMECMP_LO=0x100 -> irq falls 1 cycle after the write lands.
//  6 Same-cycle read+write to MTIMECMP_LO (0x55) -> read returns old value; subsequent read returns
//    0x55; bus_read_valid high only for the cycle after the read; assert rst_n low mid-read -> valid=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register offsets, word indices and CTRL layout.
package timer_pkg;

    localparam int BUS_ADDR_WIDTH = 5;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 5;

    // Byte offsets of the mapped registers
    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] CTRL        = 5'h10;

    // Word indices used by the decoder (byte offset / 4)
    localparam int IDX_MTIME_LO    = 0;
    localparam int IDX_MTIME_HI    = 1;
    localparam int IDX_MTIMECMP_LO = 2;
    localparam int IDX_MTIMECMP_HI = 3;
    localparam int IDX_CTRL        = 4;

    // CTRL field positions
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_DIVIDER_LSB = 8;

    function automatic logic [2:0] word_index(input logic [4:0] offset);
        return offset[4:2];
    endfunction

endpackage

// File: rtl/machine_timer_unit_if.sv
// Word-only peripheral bus between the core's data segment and the machine timer.
interface machine_timer_unit_if;

    logic [4:0]  bus_address;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_read_valid;

    modport master (
        output bus_address,
        output bus_read_enable,
        output bus_write_enable,
        output bus_write_data,
        input  bus_read_data,
        input  bus_read_valid
    );

    modport slave (
        input  bus_address,
        input  bus_read_enable,
        input  bus_write_enable,
        input  bus_write_data,
        output bus_read_data,
        output bus_read_valid
    );

endinterface

// File: rtl/timer_prescaler.sv
// Programmable divider: counts 0..divider and emits a one-cycle tick on the terminal count.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] divider_i,
    input  logic                      clear_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] count_q;
    logic [PRESCALE_WIDTH-1:0] count_d;

    assign tick_o = enable_i && (count_q == divider_i);

    // Clear wins so a new divider always starts a full period from zero
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/machine_timer_unit.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaler, tear-free high-word shadow
// and a registered level interrupt for mip.MTIP.
module machine_timer_unit
    import timer_pkg::*;
#(
    parameter int          PRESCALE_WIDTH = 8,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    machine_timer_unit_if.slave bus,
    output logic                timer_interrupt_request
);

    logic [2:0]          reg_idx;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] rd_sel;
    logic                unused_addr_bits;

    logic [63:0]               mtime_q,       mtime_d;
    logic [63:0]               mtimecmp_q,    mtimecmp_d;
    logic [31:0]               hi_shadow_q,   hi_shadow_d;
    logic                      enable_q,      enable_d;
    logic [PRESCALE_WIDTH-1:0] divider_q,     divider_d;
    logic [31:0]               rdata_q,       rdata_d;
    logic                      rvalid_q,      rvalid_d;
    logic                      irq_q,         irq_d;

    logic        tick;
    logic [31:0] ctrl_word;
    logic [31:0] read_mux;

    assign reg_idx          = bus.bus_address[4:2];
    assign unused_addr_bits = ^bus.bus_address[1:0];

    // One strobe per mapped word; unmapped indices leave every strobe low
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign wr_sel[gi] = bus.bus_write_enable && (reg_idx == 3'(gi));
        assign rd_sel[gi] = bus.bus_read_enable  && (reg_idx == 3'(gi));
    end

    timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_q),
        .divider_i (divider_q),
        .clear_i   (wr_sel[IDX_CTRL]),
        .tick_o    (tick)
    );

    // A write to either half suppresses the tick for the full 64-bit value
    always_comb begin
        mtime_d = mtime_q;
        if (wr_sel[IDX_MTIME_LO] || wr_sel[IDX_MTIME_HI]) begin
            if (wr_sel[IDX_MTIME_LO]) begin
                mtime_d[31:0] = bus.bus_write_data;
            end
            if (wr_sel[IDX_MTIME_HI]) begin
                mtime_d[63:32] = bus.bus_write_data;
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_sel[IDX_MTIMECMP_LO]) begin
            mtimecmp_d[31:0] = bus.bus_write_data;
        end
        if (wr_sel[IDX_MTIMECMP_HI]) begin
            mtimecmp_d[63:32] = bus.bus_write_data;
        end
    end

    always_comb begin
        enable_d  = enable_q;
        divider_d = divider_q;
        if (wr_sel[IDX_CTRL]) begin
            enable_d  = bus.bus_write_data[CTRL_ENABLE_BIT];
            divider_d = bus.bus_write_data[CTRL_DIVIDER_LSB +: PRESCALE_WIDTH];
        end
    end

    always_comb begin
        ctrl_word                                     = '0;
        ctrl_word[CTRL_ENABLE_BIT]                    = enable_q;
        ctrl_word[CTRL_DIVIDER_LSB +: PRESCALE_WIDTH] = divider_q;
    end

    // Reads see pre-edge state, so a same-cycle write returns the old value
    always_comb begin
        read_mux = '0;
        case (reg_idx)
            3'(IDX_MTIME_LO):    read_mux = mtime_q[31:0];
            3'(IDX_MTIME_HI):    read_mux = hi_shadow_q;
            3'(IDX_MTIMECMP_LO): read_mux = mtimecmp_q[31:0];
            3'(IDX_MTIMECMP_HI): read_mux = mtimecmp_q[63:32];
            3'(IDX_CTRL):        read_mux = ctrl_word;
            default:             read_mux = '0;
        endcase
    end

    always_comb begin
        rdata_d     = rdata_q;
        rvalid_d    = bus.bus_read_enable;
        hi_shadow_d = hi_shadow_q;
        if (bus.bus_read_enable) begin
            rdata_d = read_mux;
        end
        // Capture the upper half alongside the LO read for a tear-free 64-bit pair
        if (rd_sel[IDX_MTIME_LO]) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    assign irq_d = (mtime_q >= mtimecmp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RESET;
            hi_shadow_q <= '0;
            enable_q    <= 1'b1;
            divider_q   <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            enable_q    <= enable_d;
            divider_q   <= divider_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.bus_read_data     = rdata_q;
    assign bus.bus_read_valid    = rvalid_q;
    assign timer_interrupt_request = irq_q;

endmodule
